// File: rtl/buf_pkg.sv
// Shared line-buffer definitions: default widths, write-buffer state encoding and
// the MSB-first lane placement used by both the read and write buffers.
package buf_pkg;

  localparam int DEF_FULL_WIDTH = 512;
  localparam int DEF_WIDTH      = 64;
  localparam int DEF_MAX_ELEMS  = DEF_FULL_WIDTH / DEF_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } wbuf_state_t;

  // Slot 0 occupies the most significant lane of the line.
  function automatic int lane_lo(input int slot, input int full_w, input int w);
    return full_w - (slot + 1) * w;
  endfunction

endpackage

// File: rtl/wbuf_slot_dec.sv
// One-hot slot write enable from the write pointer and the accept strobe.
module wbuf_slot_dec #(
  parameter int N = 8
) (
  input  logic [7:0]   ptr,
  input  logic         en,
  output logic [N-1:0] we
);

  always_comb begin
    we = '0;
    for (int k = 0; k < N; k++) begin
      we[k] = en && (ptr == 8'(k));
    end
  end

endmodule

// File: rtl/write_buffer.sv
// Collects WIDTH-bit elements into one FULL_WIDTH line and issues a masked wide write.
// Optional WBUF_AUTOFLUSH_EN: a line closes by itself once its last slot is written.
module write_buffer
  import buf_pkg::*;
#(
  parameter int FULL_WIDTH = DEF_FULL_WIDTH,
  parameter int WIDTH      = DEF_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [7:0]                        base,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic                              flush,
  output logic                              wvalid,
  input  logic                              wready,
  output logic [FULL_WIDTH-1:0]             wdata,
  output logic [(FULL_WIDTH/WIDTH)-1:0]     wmask,
  output logic                              busy,
  output logic [1:0]                        dbg_state
);

  localparam int MAX_ELEMS = FULL_WIDTH / WIDTH;

`ifdef WBUF_AUTOFLUSH_EN
  localparam bit AUTOFLUSH = 1'b1;
`else
  localparam bit AUTOFLUSH = 1'b0;
`endif

  // Handshakes: an element moves when in_valid & in_ready on a rising edge; the line
  // moves when wvalid & wready. wvalid, wdata and wmask are held until that handshake.

  wbuf_state_t          state, state_next;
  logic [7:0]           wrptr, wrptr_next;
  logic [7:0]           base_eff;
  logic [7:0]           eff_ptr;
  logic                 accept;
  logic                 last_hit;
  logic                 line_clear;
  logic [MAX_ELEMS-1:0] slot_we;
  logic [MAX_ELEMS-1:0] wmask_q;
  logic [WIDTH-1:0]     slot_q [MAX_ELEMS];

  assign base_eff = (base >= 8'(MAX_ELEMS)) ? 8'd0 : base;
  // A start in EMPTY redirects an element accepted in the same cycle to the new base.
  assign eff_ptr  = (state == ST_EMPTY && start) ? base_eff : wrptr;
  assign in_ready = (state != ST_WRITE) && (wrptr < 8'(MAX_ELEMS));
  assign accept   = in_valid && in_ready;
  assign last_hit = accept && (eff_ptr == 8'(MAX_ELEMS - 1));

  assign wvalid    = (state == ST_WRITE);
  assign busy      = (state != ST_EMPTY);
  assign wmask     = wmask_q;
  assign dbg_state = state;

  wbuf_slot_dec #(.N(MAX_ELEMS)) u_slot_dec (
    .ptr (eff_ptr),
    .en  (accept),
    .we  (slot_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      wrptr <= 8'd0;
    end else begin
      state <= state_next;
      wrptr <= wrptr_next;
    end
  end

  always_comb begin
    state_next = state;
    wrptr_next = wrptr;
    line_clear = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (start) wrptr_next = base_eff;
        if (accept) begin
          wrptr_next = eff_ptr + 8'd1;
          state_next = (AUTOFLUSH && last_hit) ? ST_WRITE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) wrptr_next = eff_ptr + 8'd1;
        if (flush || (AUTOFLUSH && last_hit)) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (wready) begin
          state_next = ST_EMPTY;
          wrptr_next = 8'd0;
          line_clear = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || line_clear) begin
      wmask_q <= '0;
      for (int k = 0; k < MAX_ELEMS; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < MAX_ELEMS; k++) begin
        if (slot_we[k]) begin
          slot_q[k]                 <= in_data;
          wmask_q[MAX_ELEMS-1-k]    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    wdata = '0;
    for (int k = 0; k < MAX_ELEMS; k++) begin
      wdata[lane_lo(k, FULL_WIDTH, WIDTH) +: WIDTH] = slot_q[k];
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: vector table, directed multi-cycle sequences and random
// traffic checked against a line-level model; follows WBUF_AUTOFLUSH_EN like the DUT.
module tb_write_buffer;

  localparam int FW   = 512;
  localparam int W    = 64;
  localparam int MAXE = FW / W;
`ifdef WBUF_AUTOFLUSH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    base = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          flush = 1'b0;
  logic          wvalid;
  logic          wready = 1'b0;
  logic [FW-1:0] wdata;
  logic [MAXE-1:0] wmask;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  write_buffer #(.FULL_WIDTH(FW), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wmask(wmask), .busy(busy), .dbg_state(dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [FW-1:0]   exp_q[$];
  logic [MAXE-1:0] mask_q[$];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (line contents) ----------------
  bit            m_pending;
  int            m_count;
  int            m_ptr;
  logic [W-1:0]  m_line [MAXE];
  logic [MAXE-1:0] m_mask;

  task automatic clear_model();
    m_pending = 1'b0;
    m_count   = 0;
    m_ptr     = 0;
    m_mask    = '0;
    for (int k = 0; k < MAXE; k++) m_line[k] = '0;
  endtask

  task automatic push_line();
    logic [FW-1:0] l;
    l = '0;
    for (int k = 0; k < MAXE; k++) l[FW-1-W*k -: W] = m_line[k];
    exp_q.push_back(l);
    mask_q.push_back(m_mask);
  endtask

  task automatic check_outputs();
    chk("in_ready", {511'd0, in_ready}, {511'd0, (!m_pending && m_ptr < MAXE)});
    chk("wvalid",   {511'd0, wvalid},   {511'd0, m_pending});
    chk("busy",     {511'd0, busy},     {511'd0, (m_pending || m_count > 0)});
    if (m_pending && exp_q.size() > 0) begin
      chk("wdata", wdata, exp_q[0]);
      chk("wmask", {504'd0, wmask}, {504'd0, mask_q[0]});
    end else if (!m_pending && m_count == 0) begin
      chk("wdata_idle", wdata, '0);
      chk("wmask_idle", {504'd0, wmask}, '0);
    end
  endtask

  task automatic model_step(input bit st, input int b, input bit v,
                            input logic [W-1:0] d, input bit fl, input bit wr);
    bit acc;
    bit last;
    int was;
    acc  = v && !m_pending && (m_ptr < MAXE);
    last = 1'b0;
    was  = m_count;
    if (m_pending) begin
      if (wr) begin
        void'(exp_q.pop_front());
        void'(mask_q.pop_front());
        clear_model();
      end
    end else begin
      if (was == 0 && st) m_ptr = (b >= MAXE) ? 0 : b;
      if (acc) begin
        m_line[m_ptr]        = d;
        m_mask[MAXE-1-m_ptr] = 1'b1;
        last                 = (m_ptr == MAXE - 1);
        m_ptr++;
        m_count++;
      end
      if ((was > 0 && fl) || (AUTO && last)) begin
        m_pending = 1'b1;
        push_line();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit st, input int b, input bit v,
                       input logic [W-1:0] d, input bit fl, input bit wr);
    start    = st;
    base     = 8'(b);
    in_valid = v;
    in_data  = d;
    flush    = fl;
    wready   = wr;
    check_outputs();
    model_step(st, b, v, d, fl, wr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; in_valid = 1'b0; flush = 1'b0; wready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
    exp_q.delete();
    mask_q.delete();
    check_outputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          st;
    int          b;
    bit          v;
    logic [W-1:0] d;
    bit          fl;
    bit          wr;
    bit          e_ready;
    bit          e_wvalid;
    bit          e_busy;
    logic [MAXE-1:0] e_mask;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // start base=5, A, B, flush, handshake
    vecs[0] = '{1'b1, 5, 1'b1, 64'hAAAA_0000_0000_0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 0, 1'b1, 64'hBBBB_0000_0000_0006, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[2] = '{1'b0, 0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'b0000_0110};
    vecs[3] = '{1'b0, 0, 1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    // flush in EMPTY, base=9 -> slot 0, start in FILL ignored, early wready ignored
    vecs[4] = '{1'b0, 0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 9, 1'b1, 64'hCCCC_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[6] = '{1'b1, 4, 1'b1, 64'hDDDD_0000_0000_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    vecs[7] = '{1'b0, 0, 1'b0, 64'h0,                   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'b1100_0000};
    vecs[8] = '{1'b0, 0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_0000};
    vecs[9] = '{1'b0, 0, 1'b0, 64'h0,                   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    clear_model();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].st, vecs[i].b, vecs[i].v, vecs[i].d, vecs[i].fl, vecs[i].wr);
      chk($sformatf("vec%0d_ready", i),  {511'd0, in_ready}, {511'd0, vecs[i].e_ready});
      chk($sformatf("vec%0d_wvalid", i), {511'd0, wvalid},   {511'd0, vecs[i].e_wvalid});
      chk($sformatf("vec%0d_busy", i),   {511'd0, busy},     {511'd0, vecs[i].e_busy});
      if (vecs[i].e_wvalid)
        chk($sformatf("vec%0d_mask", i), {504'd0, wmask}, {504'd0, vecs[i].e_mask});
    end

    // full line of 0x11..0x88; closes by itself only with autoflush
    for (int i = 0; i < MAXE; i++)
      cycle(i == 0, 0, 1'b1, 64'(8'h11 * (i + 1)), 1'b0, 1'b0);
    if (!AUTO) begin
      chk("full_no_ready", {511'd0, in_ready}, '0);
      chk("full_no_wvalid", {511'd0, wvalid}, '0);
      cycle(1'b0, 0, 1'b1, 64'hDEAD, 1'b0, 1'b0);
      cycle(1'b0, 0, 1'b0, 64'h0, 1'b1, 1'b0);
    end
    chk("full_wvalid", {511'd0, wvalid}, {511'd0, 1'b1});
    chk("full_slot0", {448'd0, wdata[FW-1 -: W]}, {448'd0, 64'h11});
    chk("full_slot7", {448'd0, wdata[W-1:0]}, {448'd0, 64'h88});
    chk("full_mask", {504'd0, wmask}, {504'd0, 8'hFF});

    // wready held low for 10 cycles: line must stay stable
    for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b1, 64'(i), 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("post_write_ready", {511'd0, in_ready}, {511'd0, 1'b1});
    chk("post_write_busy", {511'd0, busy}, '0);

    // flush together with the accept into slot 3
    cycle(1'b1, 0, 1'b1, 64'h100, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 64'h101, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 64'h102, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 64'h103, 1'b1, 1'b0);
    chk("flush_acc_mask", {504'd0, wmask}, {504'd0, 8'hF0});
    chk("flush_acc_slot3", {448'd0, wdata[FW-1-3*W -: W]}, {448'd0, 64'h103});

    // reset while the write is pending discards the line
    do_reset();
    chk("rst_wvalid", {511'd0, wvalid}, '0);
    chk("rst_busy", {511'd0, busy}, '0);
    chk("rst_wmask", {504'd0, wmask}, '0);
    cycle(1'b1, 6, 1'b1, 64'h77, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 64'h78, 1'b1, 1'b0);
    chk("fresh_mask", {504'd0, wmask}, {504'd0, 8'b0000_0011});
    cycle(1'b0, 0, 1'b0, 64'h0, 1'b0, 1'b1);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 12),
              $urandom_range(0, 9) < 6, {$urandom, $urandom},
              $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
